// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register for the RV32I core.
// Owns the PC, drives a req/ack instruction-memory port and presents the
// fetched instruction, its opcode, pc and pc+4 to decode.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request outstanding at pc; response goes to ID or the hold buffer
// DRAIN | request at drain_addr was killed by a redirect; wait and discard
// HOLD  | fetched instruction parked in the hold buffer while decode stalls
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [6:0]        id_opcode,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_pc_plus4
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc, pc_next, pc_inc;
    logic [XLEN-1:0]   redirect_target;
    logic [XLEN-1:0]   drain_addr;
    logic [31:0]       hold_instr;
    logic [XLEN-1:0]   hold_pc;
    logic [XLEN-1:0]   hold_pc_plus4;

    logic              id_load_fetch;
    logic              id_load_hold;
    logic              id_squash;
    logic              id_bubble;
    logic              hold_load;
    logic              drain_load;

    assign pc_inc          = pc + XLEN'(4);
    assign redirect_target = redirect_pc & ~XLEN'(3);

    // The port requests only in FETCH/DRAIN; DRAIN keeps the killed address
    // on the bus so the address stays stable until the memory answers.
    assign imem_req  = !rst && (state == FETCH || state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // Next-state and datapath control; priority redirect > flush > stall > ack.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        id_load_fetch = 1'b0;
        id_load_hold  = 1'b0;
        id_squash     = 1'b0;
        id_bubble     = 1'b0;
        hold_load     = 1'b0;
        drain_load    = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next   = redirect_target;
                    id_squash = 1'b1;
                    if (!imem_ack) begin
                        state_next = DRAIN;
                        drain_load = 1'b1;
                    end
                end else if (flush) begin
                    // Response is consumed (pc advances) but never reaches ID.
                    id_squash = 1'b1;
                    if (imem_ack) pc_next = pc_inc;
                end else if (stall) begin
                    if (imem_ack) begin
                        hold_load  = 1'b1;
                        pc_next    = pc_inc;
                        state_next = HOLD;
                    end
                end else if (imem_ack) begin
                    id_load_fetch = 1'b1;
                    pc_next       = pc_inc;
                end else begin
                    id_bubble = 1'b1;
                end
            end
            DRAIN: begin
                // pc already carries the pending redirect target.
                if (redirect_valid) begin
                    pc_next   = redirect_target;
                    id_squash = 1'b1;
                end else if (flush) begin
                    id_squash = 1'b1;
                end else if (!stall) begin
                    id_bubble = 1'b1;
                end
                if (imem_ack) state_next = FETCH;
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    id_squash  = 1'b1;
                    state_next = FETCH;
                end else if (flush) begin
                    id_squash  = 1'b1;
                    state_next = FETCH;
                end else if (!stall) begin
                    id_load_hold = 1'b1;
                    state_next   = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // PC, hold buffer and drain address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            drain_addr    <= '0;
            hold_instr    <= NOP_INSTR;
            hold_pc       <= '0;
            hold_pc_plus4 <= '0;
        end else begin
            pc <= pc_next;
            if (drain_load) drain_addr <= pc;
            if (hold_load) begin
                hold_instr    <= imem_rdata;
                hold_pc       <= pc;
                hold_pc_plus4 <= pc_inc;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_opcode   <= NOP_INSTR[6:0];
            id_pc       <= '0;
            id_pc_plus4 <= XLEN'(4);
        end else if (id_squash) begin
            id_valid  <= 1'b0;
            id_instr  <= NOP_INSTR;
            id_opcode <= NOP_INSTR[6:0];
        end else if (id_load_fetch) begin
            id_valid    <= 1'b1;
            id_instr    <= imem_rdata;
            id_opcode   <= imem_rdata[6:0];
            id_pc       <= pc;
            id_pc_plus4 <= pc_inc;
        end else if (id_load_hold) begin
            id_valid    <= 1'b1;
            id_instr    <= hold_instr;
            id_opcode   <= hold_instr[6:0];
            id_pc       <= hold_pc;
            id_pc_plus4 <= hold_pc_plus4;
        end else if (id_bubble) begin
            id_valid <= 1'b0;
        end
    end

endmodule
